seq_wide_adder: RTL and testbench

Pin-limited, parametrised successor to the single-cycle 6-bit prefix adder channel in the tiny Brent-Kung top. It accepts two WIDTH-bit operands as SLICE-bit beats, LSB first, over a valid/ready handshake, and computes add, subtract, add-with-carry or subtract-with-borrow with a Brent-Kung prefix network. It then streams the result back out in SLICE-bit beats with carry-out and signed-overflow flags. It sits behind the top-level pin mux as one selectable channel: A on the dedicated inputs, B on the bidirectional inputs.

---
 rtl/seq_wide_adder.sv | 153 +++++++++++++++
 tb/tb_seq_wide_adder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_wide_adder.sv
// Beat-serial wide adder: SLICE-bit operand beats in, Brent-Kung add/sub in one CALC cycle, SLICE-bit result beats out.
// Latency 2 cycles from last input handshake to first output beat; result beats and flags hold while out_ready is low.
module seq_wide_adder #(
  parameter int WIDTH = 24,
  parameter int SLICE = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SLICE-1:0] in_a,
  input  logic [SLICE-1:0] in_b,
  input  logic [1:0]       mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SLICE-1:0] out_data,
  output logic             out_last,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 2) ? $clog2(NSLICE) : 1;
  localparam int LEVELS = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (NSLICE < 2 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("seq_wide_adder: WIDTH must be a multiple of SLICE with at least two slices");
  end

  typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [1:0]       mode_q, mode_d;
  logic             cin_q, cin_d;
  logic [CW-1:0]    k_q, k_d, j_q, j_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH-1:0] b_eff, hs, gg, pp, sum;
  logic             c0, ovf_calc;

  // Brent-Kung prefix: carry-in folded into bit 0's generate, up-sweep then down-sweep.
  always_comb begin
    b_eff = mode_q[0] ? ~b_q : b_q;
    c0    = mode_q[1] ? (cin_q ^ mode_q[0]) : mode_q[0];
    hs    = a_q ^ b_eff;
    pp    = hs;
    gg    = a_q & b_eff;
    gg[0] = gg[0] | (hs[0] & c0);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    for (int l = LEVELS - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    sum      = hs ^ {gg[WIDTH-2:0], c0};
    ovf_calc = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    k_d     = k_q;
    j_d     = j_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          a_d[k_q*SLICE +: SLICE] = in_a;
          b_d[k_q*SLICE +: SLICE] = in_b;
          if (k_q == '0) begin
            mode_d = mode;
            cin_d  = cin;
          end
          if (k_q == LAST) begin
            k_d     = '0;
            state_d = CALC;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      CALC: begin
        s_d     = sum;
        cout_d  = gg[WIDTH-1];
        ovf_d   = ovf_calc;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          if (j_q == LAST) begin
            j_d     = '0;
            state_d = LOAD;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      mode_q     <= '0;
      cin_q      <= 1'b0;
      k_q        <= '0;
      j_q        <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s_q        <= s_d;
      mode_q     <= mode_d;
      cin_q      <= cin_d;
      k_q        <= k_d;
      j_q        <= j_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid && (j_q == LAST);
  assign out_data  = out_valid ? s_q[j_q*SLICE +: SLICE] : '0;
  assign cout      = out_last & cout_q;
  assign ovf       = out_last & ovf_q;

endmodule

// File: tb/tb_seq_wide_adder.sv
// Directed bench for seq_wide_adder (WIDTH=24, SLICE=6) with hand-computed results.
module tb_seq_wide_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_a, in_b;
  logic [1:0] mode;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       out_last;
  logic       cout;
  logic       ovf;

  int compares = 0;
  int fails    = 0;

  seq_wide_adder #(.WIDTH(24), .SLICE(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mode      (mode),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives nbeats operand beats; mode/cin are inverted on later beats to prove beat-0-only sampling.
  task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [1:0] m,
                      input logic c, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      int n;
      @(negedge clk);
      n = 0;
      in_valid = 1'b0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("in_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      in_a     = a[k*6 +: 6];
      in_b     = b[k*6 +: 6];
      mode     = (k == 0) ? m : ~m;
      cin      = (k == 0) ? c : ~c;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input logic [23:0] s, input logic co, input logic ov,
                      input int stall_j, input bit toggle);
    for (int j = 0; j < 4; j++) begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("out_valid", out_valid, 1);
      check($sformatf("data[%0d]", j), out_data, s[j*6 +: 6]);
      check($sformatf("last[%0d]", j), out_last, (j == 3));
      check($sformatf("cout[%0d]", j), cout, (j == 3) ? co : 1'b0);
      check($sformatf("ovf[%0d]", j), ovf, (j == 3) ? ov : 1'b0);
      check("in_ready_drain", in_ready, 0);
      if (j == stall_j) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_data", out_data, s[j*6 +: 6]);
          check("stall_valid", out_valid, 1);
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      if (toggle) begin
        in_valid = ~in_valid;
        in_a     = 6'($urandom);
        in_b     = 6'($urandom);
        mode     = 2'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("out_valid_after", out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    mode      = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // ADD FFFFFF + 1 wraps to zero with carry out
    send(24'hFFFFFF, 24'h000001, 2'b00, 1'b0, 4);
    recv(24'h000000, 1'b1, 1'b0, -1, 1'b0);

    // SUB 0 - 1 borrows
    send(24'h000000, 24'h000001, 2'b01, 1'b1, 4);
    recv(24'hFFFFFF, 1'b0, 1'b0, -1, 1'b0);

    // ADD 7FFFFF + 1 signed overflow
    send(24'h7FFFFF, 24'h000001, 2'b00, 1'b1, 4);
    recv(24'h800000, 1'b0, 1'b1, -1, 1'b0);

    // ADDC 0x10 + 0x20 + 1
    send(24'h000010, 24'h000020, 2'b10, 1'b1, 4);
    recv(24'h000031, 1'b0, 1'b0, -1, 1'b0);

    // SUBB 0x100 - 1 - 1 = 0xFE, junk in_valid during drain
    send(24'h000100, 24'h000001, 2'b11, 1'b1, 4);
    recv(24'h0000FE, 1'b1, 1'b0, -1, 1'b1);

    // Backpressure on beat 2: 0x123456 + 0x111111 = 0x234567
    send(24'h123456, 24'h111111, 2'b00, 1'b0, 4);
    recv(24'h234567, 1'b0, 1'b0, 2, 1'b0);

    // Reset during DRAIN discards the result
    send(24'h000001, 24'h000002, 2'b00, 1'b0, 4);
    @(negedge clk);
    check("drain_pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("drain_rst_valid", out_valid, 0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("drain_rst_no_beat", out_valid, 0);
    end

    // Reset after two of four beats, then a clean ADD 3 + 4
    send(24'h0AAAAA, 24'h055555, 2'b00, 1'b0, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_release_in_ready", in_ready, 1);
    send(24'h000003, 24'h000004, 2'b00, 1'b0, 4);
    check("lat_calc_valid", out_valid, 0);
    check("lat_calc_in_ready", in_ready, 0);
    @(negedge clk);
    check("lat_first_valid", out_valid, 1);
    recv(24'h000007, 1'b0, 1'b0, -1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("no_stale_beat", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
